conv3x3_window_engine: RTL and testbench
========================================

Name: conv3x3_window_engine

Overview:
- Downstream consumer of the 3x3 image window memory.
- Scans every valid window position row-major by driving addr1/addr2/ren, and takes the nine registered pixels one cycle later.
- Computes a signed 3x3 dot product with bias, requantizes to 8-bit and streams results into the feature-map memory through a wen/wadd/wdata write port.
- Started by the SoC once the image memory reports full; reports busy/done.

Parameters:
- N_R, 28, image rows.
- N_C, 28, image columns.
- ADDR_W, 10, width of addr1/addr2 and out_wadd.
- PIX_W, 16, window pixel width; signed two's complement, offset already applied upstream.
- W_W, 8, signed weight width.
- ACC_W, 32, accumulator width; bias is ACC_W signed.
- Q, 2014687024, unsigned 32-bit requant multiplier.
- SHIFT, 32, arithmetic right shift after the Q multiply.
- OFFSET_SOR, -1, signed output offset added after the shift.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse.
- img_ready  in  1  connected to window memory mem_full; start is ignored while low.
- weights  in  9*W_W  signed weights, w0 in LSBs; index k matches rdata k.
- bias  in  ACC_W  signed bias.
- ren  out  1  window read enable.
- addr1  out  ADDR_W  window top row.
- addr2  out  ADDR_W  window left column.
- rdata0..rdata8  in  PIX_W each  window pixels, valid the cycle after ren.
- out_wen  out  1  feature-map write strobe.
- out_wadd  out  ADDR_W  feature-map address = row*(N_C-2)+col.
- out_wdata  out  8  requantized result, unsigned 0..255.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; pipeline valid bits cleared; counters 0.
- States:
  - IDLE: if start && img_ready, go to SCAN; clear row/col counters; set busy.
  - SCAN: ren=1 every cycle; addr1=row, addr2=col.
    - col counts 0..N_C-3, then wraps to 0 and row increments.
    - On row=N_R-3 and col=N_C-3, go to DRAIN.
  - DRAIN: ren=0; wait until all four pipeline stages are empty; then go to DONE.
  - DONE: done=1 for one cycle, busy=0; return to IDLE.
- Pipeline: ren issued in cycle T.
  - T+1: rdata valid; nine products rdata_k*w_k (PIX_W+W_W signed) registered.
  - T+2: adder tree sum + bias registered into ACC_W signed acc.
  - T+3: acc*Q registered (ACC_W+33 signed, Q zero-extended).
  - T+4: out_wen=1 with out_wdata and out_wadd.
  - out_wdata = sat((prod >>> SHIFT) + OFFSET_SOR) to [0,255]. The shift floors toward -inf.
  - out_wadd is carried down the pipeline alongside the data, not recomputed.
- Throughput: one window per cycle, no bubbles; (N_R-2)*(N_C-2) writes per run (676 at defaults).
- First write occurs 4 cycles after the first ren. done pulses on the cycle after the last out_wen.
- start while busy: ignored. start with img_ready=0: ignored; stay IDLE.
- weights and bias are sampled every cycle; they must be held stable while busy (this is the caller's responsibility).
- Reset mid-run: abort immediately; no further ren or out_wen; done is not pulsed.
- img_ready dropping mid-run: ignored; the run completes.

Decomposition:
- Package conv_pkg holds:
  - localparams PIX_W, W_W, ACC_W, Q, SHIFT, OFFSET_SOR;
  - state enum IDLE/SCAN/DRAIN/DONE;
  - function sat_u8.
- One sub-module is natural: requant_u8 (stages T+3/T+4: multiply, shift, offset, saturate), reusable by later conv layers.

Test Plan:
- Every pixel = 7, weights all 1, bias 0, start → 676 writes, each out_wdata=28; out_wadd 0..675 in order; done one cycle after the last write.
- Pixel 261, weights all 127, bias 0 → acc=298323; out_wdata=255 (saturated high).
- Pixel 7, weights all -1 → acc=-63; floor gives -30, then -1 gives -31; out_wdata=0 (saturated low).
- Ramp image pixel=row*28+col, single weight w4=1 (others 0) → out_wdata = sat(floor(((r+1)*28+(c+1))*0.46908)-1). Check (0,0)=12 and the first write 4 cycles after the first ren.
- start with img_ready=0, then start pulsed during busy → no ren from the first; second is ignored; exactly 676 writes; one done.
- Assert rst_n=0 at write 100 → all outputs 0 the same cycle; a new start then yields a full clean run from out_wadd 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine family.
// Holds arithmetic widths, the requantisation constants, FSM states and the u8 saturator.
package conv_pkg;

  localparam int PIX_W  = 16;
  localparam int W_W    = 8;
  localparam int ACC_W  = 32;
  localparam int MUL_W  = PIX_W + W_W;
  localparam int PROD_W = ACC_W + 33;
  localparam int SHIFT  = 32;

  localparam logic [ACC_W-1:0]        Q          = 32'd2014687024;
  localparam logic signed [ACC_W-1:0] OFFSET_SOR = -32'sd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Clamp a signed wide value into the unsigned 0..255 range.
  function automatic logic [7:0] sat_u8(input logic signed [PROD_W-1:0] v);
    logic [7:0] r;
    if (v[PROD_W-1]) begin
      r = 8'd0;
    end else if (|v[PROD_W-2:8]) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv3x3_window_engine_requant.sv
// Requantiser: registers acc*Q, then shifts, offsets and saturates to an unsigned byte.
// The destination address travels alongside the data so the write port stays aligned.
module requant_u8
  import conv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [ADDR_W-1:0]       wadd_i,
  output logic                    wen_o,
  output logic [7:0]              wdata_o,
  output logic [ADDR_W-1:0]       wadd_o
);

  logic signed [PROD_W-1:0] acc_ext_s;
  logic signed [PROD_W-1:0] q_ext_s;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] shifted_s;
  logic signed [PROD_W-1:0] biased_s;
  logic                     valid_q;
  logic [ADDR_W-1:0]        wadd_q;

  // Q is an unsigned multiplier, so it is zero-extended before the signed multiply.
  assign acc_ext_s = {{(PROD_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign q_ext_s   = {{(PROD_W-ACC_W){1'b0}}, Q};
  assign prod_d    = acc_ext_s * q_ext_s;

  // Product stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      wadd_q  <= '0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_i;
      wadd_q  <= wadd_i;
    end
  end

  assign shifted_s = prod_q >>> SHIFT;
  assign biased_s  = shifted_s + {{(PROD_W-ACC_W){OFFSET_SOR[ACC_W-1]}}, OFFSET_SOR};

  assign wen_o   = valid_q;
  assign wdata_o = valid_q ? sat_u8(biased_s) : 8'd0;
  assign wadd_o  = valid_q ? wadd_q : '0;

endmodule

// File: rtl/conv3x3_window_engine.sv
// Scans all 3x3 window positions of the image memory, convolves each with signed weights plus
// bias and streams requantised bytes to the feature-map write port, one window per cycle.
module conv3x3_window_engine
  import conv_pkg::*;
#(
  parameter int N_R    = 28,
  parameter int N_C    = 28,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    img_ready,
  input  logic [9*W_W-1:0]        weights,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    ren,
  output logic [ADDR_W-1:0]       addr1,
  output logic [ADDR_W-1:0]       addr2,
  input  logic [PIX_W-1:0]        rdata0,
  input  logic [PIX_W-1:0]        rdata1,
  input  logic [PIX_W-1:0]        rdata2,
  input  logic [PIX_W-1:0]        rdata3,
  input  logic [PIX_W-1:0]        rdata4,
  input  logic [PIX_W-1:0]        rdata5,
  input  logic [PIX_W-1:0]        rdata6,
  input  logic [PIX_W-1:0]        rdata7,
  input  logic [PIX_W-1:0]        rdata8,
  output logic                    out_wen,
  output logic [ADDR_W-1:0]       out_wadd,
  output logic [7:0]              out_wdata,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(N_R - 3);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(N_C - 3);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        row_q, row_d, col_q, col_d, widx_q, widx_d;
  logic [PIX_W-1:0]         pix_s [9];
  logic signed [MUL_W-1:0]  mul_d [9];
  logic signed [MUL_W-1:0]  mul_q [9];
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic                     v0_q, v1_q, v2_q;
  logic [ADDR_W-1:0]        wadd0_q, wadd1_q, wadd2_q;

  assign pix_s[0] = rdata0;
  assign pix_s[1] = rdata1;
  assign pix_s[2] = rdata2;
  assign pix_s[3] = rdata3;
  assign pix_s[4] = rdata4;
  assign pix_s[5] = rdata5;
  assign pix_s[6] = rdata6;
  assign pix_s[7] = rdata7;
  assign pix_s[8] = rdata8;

  assign ren   = (state_q == SCAN);
  assign addr1 = ren ? row_q : '0;
  assign addr2 = ren ? col_q : '0;
  assign busy  = (state_q == SCAN) || (state_q == DRAIN);
  assign done  = (state_q == DONE);

  // Next-state and scan-counter logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    widx_d  = widx_q;
    case (state_q)
      IDLE: begin
        if (start && img_ready) begin
          state_d = SCAN;
          row_d   = '0;
          col_d   = '0;
          widx_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        widx_d = widx_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      // Leave as the final product enters the requantiser so done lands right after the last write.
      DRAIN: begin
        if (!(v0_q || v1_q || v2_q)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      widx_q  <= widx_d;
    end
  end

  // Per-tap signed products.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      mul_d[k] = $signed({{W_W{pix_s[k][PIX_W-1]}}, pix_s[k]})
               * $signed({{PIX_W{weights[k*W_W+W_W-1]}}, weights[k*W_W +: W_W]});
    end
  end

  // Adder tree plus bias.
  always_comb begin
    acc_d = bias;
    for (int k = 0; k < 9; k++) begin
      acc_d = acc_d + {{(ACC_W-MUL_W){mul_q[k][MUL_W-1]}}, mul_q[k]};
    end
  end

  // Front pipeline: read-data valid, products, accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      wadd0_q <= '0;
      wadd1_q <= '0;
      wadd2_q <= '0;
      acc_q   <= '0;
      for (int k = 0; k < 9; k++) begin
        mul_q[k] <= '0;
      end
    end else begin
      v0_q    <= ren;
      wadd0_q <= widx_q;
      v1_q    <= v0_q;
      wadd1_q <= wadd0_q;
      v2_q    <= v1_q;
      wadd2_q <= wadd1_q;
      acc_q   <= acc_d;
      for (int k = 0; k < 9; k++) begin
        mul_q[k] <= mul_d[k];
      end
    end
  end

  requant_u8 #(.ADDR_W(ADDR_W)) u_requant (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (v2_q),
    .acc_i   (acc_q),
    .wadd_i  (wadd2_q),
    .wen_o   (out_wen),
    .wdata_o (out_wdata),
    .wadd_o  (out_wadd)
  );

endmodule

// File: tb/tb_conv3x3_window_engine.sv
// Self-checking bench: window-memory model, arithmetic reference model and directed runs.
module tb_conv3x3_window_engine;

  localparam int NR = 28;
  localparam int NC = 28;
  localparam int NW = (NR - 2) * (NC - 2);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               img_ready = 1'b0;
  logic [71:0]        weights = 72'd0;
  logic signed [31:0] bias = 32'sd0;
  logic               ren;
  logic [9:0]         addr1, addr2;
  logic [15:0]        rdata [9];
  logic               out_wen;
  logic [9:0]         out_wadd;
  logic [7:0]         out_wdata;
  logic               busy, done;

  int img [NR][NC];
  int wv [9];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nren, nwr, ndone, first_ren, first_wr, last_wr, done_cyc, first_data;

  conv3x3_window_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_ready(img_ready),
    .weights(weights), .bias(bias), .ren(ren), .addr1(addr1), .addr2(addr2),
    .rdata0(rdata[0]), .rdata1(rdata[1]), .rdata2(rdata[2]), .rdata3(rdata[3]),
    .rdata4(rdata[4]), .rdata5(rdata[5]), .rdata6(rdata[6]), .rdata7(rdata[7]),
    .rdata8(rdata[8]), .out_wen(out_wen), .out_wadd(out_wadd), .out_wdata(out_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered 3x3 window memory: tap k = dr*3 + dc.
  always @(posedge clk) begin
    if (ren && addr1 <= NR - 3 && addr2 <= NC - 3) begin
      for (int k = 0; k < 9; k++) begin
        rdata[k] <= 16'(img[int'(addr1) + k / 3][int'(addr2) + k % 3]);
      end
    end
  end

  function automatic int quant(longint acc);
    longint p;
    p = acc * 64'sd2014687024;
    p = p >>> 32;
    p = p - 64'sd1;
    if (p < 0) return 0;
    if (p > 255) return 255;
    return int'(p);
  endfunction

  function automatic int expect_at(int idx);
    int r, c;
    longint acc;
    r = idx / (NC - 2);
    c = idx % (NC - 2);
    acc = longint'(bias);
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        acc += longint'(img[r + dr][c + dc]) * longint'(wv[dr * 3 + dc]);
    return quant(acc);
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren) begin
        check("ren_addr1", addr1, nren / (NC - 2));
        check("ren_addr2", addr2, nren % (NC - 2));
        if (nren == 0) first_ren = cyc;
        nren++;
      end
      if (out_wen) begin
        if (nwr >= NW) begin
          check("extra_write", nwr, NW - 1);
        end else begin
          check("wadd", out_wadd, nwr);
          check("wdata", out_wdata, expect_at(nwr));
        end
        if (nwr == 0) begin
          first_wr = cyc;
          first_data = out_wdata;
        end
        last_wr = cyc;
        nwr++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_counts();
    nren = 0; nwr = 0; ndone = 0;
    first_ren = -1; first_wr = -1; last_wr = -1; done_cyc = -1; first_data = -1;
  endtask

  task automatic fill_const(int v);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        img[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        img[r][c] = r * NC + c;
  endtask

  task automatic set_weights(int all_v, bit center_only);
    for (int k = 0; k < 9; k++) begin
      wv[k] = center_only ? ((k == 4) ? 1 : 0) : all_v;
      weights[k*8 +: 8] = 8'(wv[k]);
    end
  endtask

  task automatic run(int exp_first, bit disturb);
    bit did;
    did = 1'b0;
    clear_counts();
    @(negedge clk);
    img_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      @(negedge clk);
      #1;
      if (start) begin
        start = 1'b0;
      end else if (disturb && !did && nwr == 10) begin
        start = 1'b1;
        img_ready = 1'b0;
        did = 1'b1;
      end
    end
    start = 1'b0;
    if (ndone == 0) check("run_timeout", 0, 1);
    @(negedge clk);
    #1;
    check("ren_count", nren, NW);
    check("write_count", nwr, NW);
    check("done_count", ndone, 1);
    check("first_write_latency", first_wr - first_ren, 4);
    check("done_after_last_write", done_cyc - last_wr, 1);
    check("first_wdata_literal", first_data, exp_first);
    check("busy_idle", busy, 0);
    img_ready = 1'b1;
  endtask

  task automatic check_all_zero();
    check("rst_ren", ren, 0);
    check("rst_addr1", addr1, 0);
    check("rst_addr2", addr2, 0);
    check("rst_out_wen", out_wen, 0);
    check("rst_out_wadd", out_wadd, 0);
    check("rst_out_wdata", out_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  initial begin
    clear_counts();
    fill_const(0);
    set_weights(0, 1'b0);
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;

    // Constant 7 with unit weights: acc 63 -> 28 everywhere.
    fill_const(7);
    set_weights(1, 1'b0);
    run(28, 1'b0);

    // Saturate high: acc 298323.
    fill_const(261);
    set_weights(127, 1'b0);
    run(255, 1'b0);

    // Saturate low: acc -63 floors to -30, minus one.
    fill_const(7);
    set_weights(-1, 1'b0);
    run(0, 1'b0);

    // Ramp with centre tap only: (0,0) sees pixel 29.
    fill_ramp();
    set_weights(0, 1'b1);
    run(12, 1'b0);

    // Start while not ready is ignored.
    clear_counts();
    @(negedge clk);
    img_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("not_ready_no_ren", nren, 0);
    check("not_ready_idle", busy, 0);

    // Start during busy and img_ready drop mid-run are ignored.
    run(12, 1'b1);

    // Asynchronous reset at write 100, then a clean rerun.
    fill_const(7);
    set_weights(1, 1'b0);
    clear_counts();
    @(negedge clk);
    img_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && nwr < 100; i++) begin
      @(negedge clk);
      #1;
    end
    check("reached_write_100", nwr, 100);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_writes", nwr, 100);
    check("abort_no_done", ndone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(28, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
